// File: rtl/decode_hold_if.sv
// Handshake/bus bundle for decode_hold: binary code in, one-hot select out.
// The master drives the code; the slave (decode_hold) returns ready and the
// registered one-hot output with its valid flag.
interface decode_hold_if;
    logic [3:0]  de_in;
    logic        de_valid;
    logic        de_ready;
    logic [15:0] de_out;
    logic        out_valid;

    modport master (
        output de_in,
        output de_valid,
        input  de_ready,
        input  de_out,
        input  out_valid
    );

    modport slave (
        input  de_in,
        input  de_valid,
        output de_ready,
        output de_out,
        output out_valid
    );
endinterface

// File: rtl/decode_hold.sv
// decode_hold: registered 4-to-16 one-hot decoder with programmable hold time
// and an automatic 0..MAX_CODE scan sweep for driving row/digit selects.
// Optional feature macro: DECODE_RANGE_CHK_EN -- when defined, codes above
// MAX_CODE are accepted but not decoded, and err pulses for one cycle.
module decode_hold #(
    parameter int HOLD_CYCLES = 4,
    parameter int MAX_CODE    = 9,
    parameter int CNT_W       = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          scan_start,
    decode_hold_if.slave  bus,
    output logic          scan_done,
    output logic          err
);

    // A hold time of zero behaves like a single-cycle hold.
    localparam int               HOLD_EFF    = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
    localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(HOLD_EFF - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [3:0]       LAST_CODE   = 4'(MAX_CODE);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HOLD = 2'd1;
    localparam logic [1:0] ST_SCAN = 2'd2;

    logic [1:0]       state_r;
    logic [CNT_W-1:0] hold_cnt_r;
    logic [3:0]       scan_code_r;
    logic [15:0]      de_out_r;
    logic             out_valid_r;
    logic             scan_done_r;
    logic             err_r;

    logic             ready_s;
    logic             accept_s;

    // Binary code to one-hot select; MAX_CODE <= 15 keeps the shift in range.
    function automatic logic [15:0] onehot16(input logic [3:0] code);
        onehot16 = 16'h0001 << code;
    endfunction

`ifdef DECODE_RANGE_CHK_EN
    // True when the code lies within the decodable range 0..MAX_CODE.
    function automatic logic in_range(input logic [3:0] code);
        in_range = (code <= LAST_CODE);
    endfunction
`endif

    assign ready_s       = (state_r == ST_IDLE) && enable && !rst;
    assign accept_s      = bus.de_valid && ready_s;

    assign bus.de_ready  = ready_s;
    assign bus.de_out    = de_out_r;
    assign bus.out_valid = out_valid_r;
    assign scan_done     = scan_done_r;
    assign err           = err_r;

    // Decoder FSM: accepts codes or scan requests in IDLE, times the hold, steps the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            hold_cnt_r  <= CNT_ZERO;
            scan_code_r <= 4'd0;
            de_out_r    <= 16'h0000;
            out_valid_r <= 1'b0;
            scan_done_r <= 1'b0;
            err_r       <= 1'b0;
        end else if (!enable) begin
            // Abort: clear everything; an interrupted scan never reports done.
            state_r     <= ST_IDLE;
            hold_cnt_r  <= CNT_ZERO;
            scan_code_r <= 4'd0;
            de_out_r    <= 16'h0000;
            out_valid_r <= 1'b0;
            scan_done_r <= 1'b0;
            err_r       <= 1'b0;
        end else begin
            scan_done_r <= 1'b0;
            err_r       <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
`ifdef DECODE_RANGE_CHK_EN
                        if (!in_range(bus.de_in)) begin
                            // Handshake completes but nothing is driven.
                            err_r       <= 1'b1;
                            de_out_r    <= 16'h0000;
                            out_valid_r <= 1'b0;
                            state_r     <= ST_IDLE;
                        end else begin
                            de_out_r    <= onehot16(bus.de_in);
                            out_valid_r <= 1'b1;
                            hold_cnt_r  <= HOLD_RELOAD;
                            state_r     <= ST_HOLD;
                        end
`else
                        de_out_r    <= onehot16(bus.de_in);
                        out_valid_r <= 1'b1;
                        hold_cnt_r  <= HOLD_RELOAD;
                        state_r     <= ST_HOLD;
`endif
                    end else if (scan_start) begin
                        // de_valid has priority, so reaching here means no code was offered.
                        de_out_r    <= 16'h0001;
                        out_valid_r <= 1'b1;
                        scan_code_r <= 4'd0;
                        hold_cnt_r  <= HOLD_RELOAD;
                        state_r     <= ST_SCAN;
                    end else begin
                        de_out_r    <= 16'h0000;
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (hold_cnt_r == CNT_ZERO) begin
                        de_out_r    <= 16'h0000;
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end else begin
                        hold_cnt_r  <= hold_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_SCAN: begin
                    if (hold_cnt_r == CNT_ZERO) begin
                        if (scan_code_r == LAST_CODE) begin
                            de_out_r    <= 16'h0000;
                            out_valid_r <= 1'b0;
                            scan_code_r <= 4'd0;
                            scan_done_r <= 1'b1;
                            state_r     <= ST_IDLE;
                        end else begin
                            // Next code follows immediately: no gap inside a sweep.
                            scan_code_r <= scan_code_r + 4'd1;
                            de_out_r    <= de_out_r << 1;
                            hold_cnt_r  <= HOLD_RELOAD;
                        end
                    end else begin
                        hold_cnt_r  <= hold_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    hold_cnt_r  <= CNT_ZERO;
                    scan_code_r <= 4'd0;
                    de_out_r    <= 16'h0000;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_hold.sv
// Self-checking bench for decode_hold: directed vector table, hand-written
// scan/abort sequences and random stimulus against a plan-queue model.
module tb_decode_hold;

    localparam int HOLD = 4;
    localparam int MAXC = 9;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b1;
    logic scan_start = 1'b0;
    logic scan_done;
    logic err;

    decode_hold_if bus ();

    decode_hold #(.HOLD_CYCLES(HOLD), .MAX_CODE(MAXC), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .scan_start (scan_start),
        .bus        (bus),
        .scan_done  (scan_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: a queue of the one-hot words still to be shown.
    typedef struct {
        logic [15:0] v;
        bit          last;
    } ent_t;
    ent_t        plan[$];
    logic [15:0] m_out   = 16'h0000;
    bit          m_valid = 1'b0;
    bit          m_done  = 1'b0;
    bit          m_err   = 1'b0;
    bit          m_pend  = 1'b0;

    typedef struct {
        bit          rst;
        bit          en;
        bit          v;
        logic [3:0]  din;
        bit          ss;
        logic [15:0] out;
        bit          valid;
        bit          done;
        bit          ready;
        bit          err;
    } vec_t;
    vec_t tbl[20];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        ent_t e;
        if (rst || !enable) begin
            plan.delete();
            m_out = 16'h0000; m_valid = 1'b0; m_done = 1'b0; m_err = 1'b0; m_pend = 1'b0;
        end else begin
            bit was_idle;
            was_idle = !m_valid;
            m_err  = 1'b0;
            m_done = 1'b0;
            if (was_idle) begin
                if (bus.de_valid) begin
`ifdef DECODE_RANGE_CHK_EN
                    if (int'(bus.de_in) > MAXC) m_err = 1'b1;
                    else for (int i = 0; i < HOLD; i++) plan.push_back('{16'h0001 << bus.de_in, 1'b0});
`else
                    for (int i = 0; i < HOLD; i++) plan.push_back('{16'h0001 << bus.de_in, 1'b0});
`endif
                end else if (scan_start) begin
                    for (int c = 0; c <= MAXC; c++)
                        for (int i = 0; i < HOLD; i++)
                            plan.push_back('{16'h0001 << c, (c == MAXC) && (i == HOLD - 1)});
                end
            end
            if (plan.size() > 0) begin
                e = plan.pop_front();
                m_out = e.v; m_valid = 1'b1; m_pend = e.last;
            end else begin
                m_out = 16'h0000; m_valid = 1'b0; m_done = m_pend; m_pend = 1'b0;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("model_de_out",    bus.de_out, m_out);
        chk("model_out_valid", {15'd0, bus.out_valid}, {15'd0, m_valid});
        chk("model_scan_done", {15'd0, scan_done}, {15'd0, m_done});
        chk("model_err",       {15'd0, err}, {15'd0, m_err});
        chk("model_de_ready",  {15'd0, bus.de_ready}, {15'd0, (!m_valid && enable && !rst)});
    endtask

    function automatic vec_t mk(bit v, logic [3:0] din, bit ss, logic [15:0] out,
                                bit valid, bit ready, bit e);
        vec_t r;
        r.rst = 1'b0; r.en = 1'b1; r.v = v; r.din = din; r.ss = ss;
        r.out = out; r.valid = valid; r.done = 1'b0; r.ready = ready; r.err = e;
        return r;
    endfunction

    task automatic reach_code4();
        int n;
        n = 0;
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        while (bus.de_out !== 16'h0010 && n < 100) begin
            step();
            n++;
        end
        chk("scan_reaches_code4", {15'd0, (n < 100)}, 16'd1);
    endtask

    initial begin
        bus.de_in    = 4'd0;
        bus.de_valid = 1'b0;

        // T1: reset held three cycles with enable high
        rst = 1'b1; enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_de_out", bus.de_out, 16'h0000);
            chk("rst_out_valid", {15'd0, bus.out_valid}, 16'd0);
            chk("rst_de_ready", {15'd0, bus.de_ready}, 16'd0);
        end
        rst = 1'b0;
        step();
        chk("post_rst_de_ready", {15'd0, bus.de_ready}, 16'd1);

        // T2, T4 and T6 as a vector table
        tbl[0] = mk(1'b1, 4'd5, 1'b0, 16'h0020, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 4; i++) tbl[i] = mk(1'b0, 4'd0, 1'b0, 16'h0020, 1'b1, 1'b0, 1'b0);
        tbl[4] = mk(1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        tbl[5] = mk(1'b1, 4'd3, 1'b1, 16'h0008, 1'b1, 1'b0, 1'b0);
        for (int i = 6; i < 9; i++) tbl[i] = mk(1'b1, 4'd7, 1'b0, 16'h0008, 1'b1, 1'b0, 1'b0);
        tbl[9]  = mk(1'b1, 4'd7, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        tbl[10] = mk(1'b1, 4'd7, 1'b0, 16'h0080, 1'b1, 1'b0, 1'b0);
        for (int i = 11; i < 14; i++) tbl[i] = mk(1'b0, 4'd0, 1'b0, 16'h0080, 1'b1, 1'b0, 1'b0);
        tbl[14] = mk(1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
`ifdef DECODE_RANGE_CHK_EN
        tbl[15] = mk(1'b1, 4'd12, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        for (int i = 16; i < 20; i++) tbl[i] = mk(1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
`else
        tbl[15] = mk(1'b1, 4'd12, 1'b0, 16'h1000, 1'b1, 1'b0, 1'b0);
        for (int i = 16; i < 19; i++) tbl[i] = mk(1'b0, 4'd0, 1'b0, 16'h1000, 1'b1, 1'b0, 1'b0);
        tbl[19] = mk(1'b0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
`endif
        for (int i = 0; i < 20; i++) begin
            rst = tbl[i].rst; enable = tbl[i].en;
            bus.de_valid = tbl[i].v; bus.de_in = tbl[i].din; scan_start = tbl[i].ss;
            step();
            chk($sformatf("vec%0d_de_out", i), bus.de_out, tbl[i].out);
            chk($sformatf("vec%0d_out_valid", i), {15'd0, bus.out_valid}, {15'd0, tbl[i].valid});
            chk($sformatf("vec%0d_scan_done", i), {15'd0, scan_done}, {15'd0, tbl[i].done});
            chk($sformatf("vec%0d_de_ready", i), {15'd0, bus.de_ready}, {15'd0, tbl[i].ready});
            chk($sformatf("vec%0d_err", i), {15'd0, err}, {15'd0, tbl[i].err});
        end
        bus.de_valid = 1'b0; scan_start = 1'b0;

        // T3: full sweep, each code held HOLD cycles, then a done pulse
        scan_start = 1'b1;
        step();
        scan_start = 1'b0;
        chk("scan_k0", bus.de_out, 16'h0001);
        for (int k = 1; k < (MAXC + 1) * HOLD; k++) begin
            step();
            chk($sformatf("scan_k%0d", k), bus.de_out, 16'h0001 << (k / HOLD));
            chk($sformatf("scan_k%0d_nodone", k), {15'd0, scan_done}, 16'd0);
        end
        step();
        chk("scan_end_de_out", bus.de_out, 16'h0000);
        chk("scan_end_done", {15'd0, scan_done}, 16'd1);
        step();
        chk("scan_done_one_cycle", {15'd0, scan_done}, 16'd0);

        // T5: abort a sweep on code 4 via enable, then via rst
        reach_code4();
        enable = 1'b0;
        step();
        chk("abort_en_de_out", bus.de_out, 16'h0000);
        chk("abort_en_done", {15'd0, scan_done}, 16'd0);
        enable = 1'b1;
        for (int i = 0; i < 45; i++) step();
        reach_code4();
        rst = 1'b1;
        step();
        chk("abort_rst_de_out", bus.de_out, 16'h0000);
        chk("abort_rst_done", {15'd0, scan_done}, 16'd0);
        rst = 1'b0;
        for (int i = 0; i < 45; i++) step();

        // Random traffic against the model
        for (int i = 0; i < 2000; i++) begin
            rst          = ($urandom_range(0, 299) == 0);
            enable       = ($urandom_range(0, 59) != 0);
            bus.de_valid = ($urandom_range(0, 2) == 0);
            bus.de_in    = 4'($urandom_range(0, 15));
            scan_start   = ($urandom_range(0, 11) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
